// File: rtl/lstm_cell_update.sv
// lstm_cell_update: serial LSTM cell-state / hidden-output update with per-cell state memory.
// lstm_tanh_pwl is the combinational tanh used by the TNH step. It is a piecewise-linear, odd-symmetric curve:
//   |x| <  0.5  : y = |x|
//   |x| <  1.0  : y = |x|/2  + 0.25
//   |x| <  2.0  : y = |x|/8  + 0.625
//   |x| <  4.0  : y = |x|/16 + 0.75
//   otherwise   : y = 1.0
// The sign of x is then reapplied to y.

module lstm_tanh_pwl #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);
    localparam logic [WIDTH-1:0] HALF           = WIDTH'(1) << (FRAC - 1);
    localparam logic [WIDTH-1:0] QUARTER        = WIDTH'(1) << (FRAC - 2);
    localparam logic [WIDTH-1:0] ONE            = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] TWO            = WIDTH'(2) << FRAC;
    localparam logic [WIDTH-1:0] FOUR           = WIDTH'(4) << FRAC;
    localparam logic [WIDTH-1:0] FIVE_EIGHTHS   = WIDTH'(5) << (FRAC - 3);
    localparam logic [WIDTH-1:0] THREE_QUARTERS = WIDTH'(3) << (FRAC - 2);

    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] mag_y;

    // Evaluate the curve on the magnitude, then restore the sign.
    // The magnitude of the most negative input is 2**(WIDTH-1) as an unsigned value, which lands in the 1.0 segment.
    always_comb begin
        mag = x[WIDTH-1] ? -x : x;
        if (mag < HALF)
            mag_y = mag;
        else if (mag < ONE)
            mag_y = (mag >> 1) + QUARTER;
        else if (mag < TWO)
            mag_y = (mag >> 3) + FIVE_EIGHTHS;
        else if (mag < FOUR)
            mag_y = (mag >> 4) + THREE_QUARTERS;
        else
            mag_y = ONE;
        y = x[WIDTH-1] ? -$signed(mag_y) : $signed(mag_y);
    end
endmodule

// State table
//   state | meaning
//   IDLE  | waiting for i_start
//   FC    | p1 = f * c_prev
//   IG    | p2 = i * g
//   ADD   | c = p1 + p2, written back to the cell memory
//   TNH   | t = tanh(c)
//   OH    | h = o * t, result registers loaded
//   DONE  | o_valid pulse; a new start may be taken here
module lstm_cell_update #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int NUM   = 8,
    parameter int ADDR  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [ADDR-1:0]  i_idx,
    input  logic             i_clr_state,
    input  logic [WIDTH-1:0] i_f,
    input  logic [WIDTH-1:0] i_i,
    input  logic [WIDTH-1:0] i_o,
    input  logic [WIDTH-1:0] i_g,
    output logic             o_busy,
    output logic             o_valid,
    output logic [ADDR-1:0]  o_idx,
    output logic [WIDTH-1:0] o_c,
    output logic [WIDTH-1:0] o_h
);
    typedef enum logic [2:0] {IDLE, FC, IG, ADD, TNH, OH, DONE} state_t;

    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state;
    state_t state_next;

    logic signed [WIDTH-1:0]   f_r, i_r, o_r, g_r, c_prev;
    logic signed [WIDTH-1:0]   p1, p2, c_r, t_r;
    logic [ADDR-1:0]           idx_r;
    logic signed [WIDTH-1:0]   mem [NUM];

    logic signed [WIDTH-1:0]   mul_a, mul_b, mul_sat, sum_sat, tanh_y;
    logic signed [2*WIDTH-1:0] prod, prod_sh;
    logic signed [WIDTH:0]     sum;
    logic                      accept;

    assign o_busy  = (state == FC) || (state == IG) || (state == ADD) ||
                     (state == TNH) || (state == OH);
    assign o_valid = (state == DONE);
    assign accept  = ((state == IDLE) || (state == DONE)) && i_start;

    lstm_tanh_pwl #(.WIDTH(WIDTH), .FRAC(FRAC)) u_tanh (
        .x (c_r),
        .y (tanh_y)
    );

    // The single shared multiplier: operands are selected by state, then the product is scaled and saturated.
    // The saturating adder is also computed here.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            FC: begin
                mul_a = f_r;
                mul_b = c_prev;
            end
            IG: begin
                mul_a = i_r;
                mul_b = g_r;
            end
            OH: begin
                mul_a = o_r;
                mul_b = t_r;
            end
            default: ;
        endcase
        prod    = {{WIDTH{mul_a[WIDTH-1]}}, mul_a} * {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
        prod_sh = prod >>> FRAC;
        if ((&prod_sh[2*WIDTH-1:WIDTH-1]) || (~|prod_sh[2*WIDTH-1:WIDTH-1]))
            mul_sat = prod_sh[WIDTH-1:0];
        else if (prod_sh[2*WIDTH-1])
            mul_sat = MINV;
        else
            mul_sat = MAXV;

        sum = {p1[WIDTH-1], p1} + {p2[WIDTH-1], p2};
        if (sum[WIDTH] == sum[WIDTH-1])
            sum_sat = sum[WIDTH-1:0];
        else if (sum[WIDTH])
            sum_sat = MINV;
        else
            sum_sat = MAXV;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: a fixed walk from FC to DONE once a start has been accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = i_start ? FC : IDLE;
            FC:      state_next = IG;
            IG:      state_next = ADD;
            ADD:     state_next = TNH;
            TNH:     state_next = OH;
            OH:      state_next = DONE;
            DONE:    state_next = i_start ? FC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, intermediate products and result registers.
    // A clear in the same cycle as a start makes the update see c_prev = 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_r    <= '0;
            i_r    <= '0;
            o_r    <= '0;
            g_r    <= '0;
            c_prev <= '0;
            idx_r  <= '0;
            p1     <= '0;
            p2     <= '0;
            c_r    <= '0;
            t_r    <= '0;
            o_idx  <= '0;
            o_c    <= '0;
            o_h    <= '0;
        end else begin
            if (accept) begin
                f_r    <= i_f;
                i_r    <= i_i;
                o_r    <= i_o;
                g_r    <= i_g;
                idx_r  <= i_idx;
                c_prev <= i_clr_state ? '0 : mem[i_idx];
            end
            case (state)
                FC:  p1  <= mul_sat;
                IG:  p2  <= mul_sat;
                ADD: c_r <= sum_sat;
                TNH: t_r <= tanh_y;
                OH: begin
                    o_h   <= mul_sat;
                    o_c   <= c_r;
                    o_idx <= idx_r;
                end
                default: ;
            endcase
        end
    end

    // Cell-state memory: the write-back happens in ADD, and the bulk clear is honoured only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM; k++)
                mem[k] <= '0;
        end else if (state == ADD) begin
            mem[idx_r] <= sum_sat;
        end else if (!o_busy && i_clr_state) begin
            for (int k = 0; k < NUM; k++)
                mem[k] <= '0;
        end
    end
endmodule
